vote_ballot_collector: RTL and testbench
========================================

Name: vote_ballot_collector

Overview:
- Upstream stage of the weighted voter; converts a serial stream of individual ballots into the parallel np/vip/vvip bitmaps that the voter consumes.
- Ballots arrive one per cycle on a valid/ready handshake. A close request freezes the round, and the bitmap is presented under out_valid/out_ready.
- After the handoff, the bitmaps clear and the next round begins.

Parameters:
- NP_N, 32, number of normal voters (width of np)
- VIP_N, 8, number of VIP voters (width of vip)
- CNT_W, 8, width of round counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ballot present
- in_ready  out  1  collector accepts ballot
- in_class  in  2  0=np, 1=vip, 2=vvip, 3=illegal
- in_id  in  5  voter index within class
- in_vote  in  1  1=cast yes, 0=retract
- close  in  1  end-of-round request (single-cycle or held)
- np  out  NP_N  normal-voter bitmap
- vip  out  VIP_N  VIP bitmap
- vvip  out  1  VVIP bit
- out_valid  out  1  bitmaps frozen and valid for the voter
- out_ready  in  1  voter consumed the bitmaps
- err  out  1  one-cycle pulse: accepted ballot was illegal
- round_cnt  out  CNT_W  completed rounds, wraps

Behaviour:
- Reset (reset=0, asynchronous): state=COLLECT, np=0, vip=0, vvip=0, out_valid=0, err=0, round_cnt=0. in_ready=1 is asserted once reset is released.
- All outputs are registered. in_ready and out_valid are decoded from the state register.
- FSM has two states, COLLECT and PRESENT.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid&in_ready. The addressed bit is set to in_vote at the same edge, so it is visible on np/vip/vvip from the following cycle.
  - Addressing: class 0 uses np[in_id]. Class 1 uses vip[in_id] and requires in_id<VIP_N. Class 2 uses vvip and requires in_id==0.
  - Duplicate casts are idempotent. A retract of an unset bit is a no-op; neither raises err.
  - Illegal ballot (class 3, vip id>=VIP_N, vvip id!=0): the ballot is consumed, no bitmap change, and err=1 for exactly the next cycle.
  - close=1 moves to PRESENT at the next edge. A ballot accepted in the same cycle as close is included in the round.
- PRESENT:
  - in_ready=0, out_valid=1. np/vip/vvip are held stable. close is ignored.
  - When out_valid&out_ready: at that edge np/vip/vvip clear to 0, round_cnt increments (wraps 2^CNT_W-1 -> 0), and the state returns to COLLECT.
  - in_ready=1 again the cycle after the handshake.
  - out_ready may be held high in advance. The handshake then completes on the first PRESENT cycle, giving a minimum round-close latency of 2 cycles from close.
- err is independent of state. It can only be produced in COLLECT, because ballots are only accepted there.
- Reset mid-round or mid-PRESENT: the pending round is discarded and round_cnt returns to 0.
- np/vip/vvip are visible during COLLECT, but downstream samples them only while out_valid=1.

Decomposition:
- Package vote_pkg holds:
  - class codes CLS_NP=2'd0, CLS_VIP=2'd1, CLS_VVIP=2'd2, CLS_BAD=2'd3;
  - defaults NP_N=32, VIP_N=8;
  - state encoding COLLECT=1'b0, PRESENT=1'b1.
- One natural sub-module, vote_decode (combinational). It maps in_class/in_id to one-hot set masks np_hit[NP_N-1:0], vip_hit[VIP_N-1:0], vvip_hit, plus an illegal flag.
- The top level holds the FSM, the bitmap registers, err and round_cnt.

Test Plan:
- Reset low 2 cycles, then high -> all bitmaps 0, out_valid=0, in_ready=1, round_cnt=0.
- Ballots (0,2,1),(0,7,1),(1,3,1),(2,0,1), then close -> PRESENT with np=32'h84, vip=8'h08, vvip=1, out_valid=1. out_ready held 0 for 3 cycles -> values stable and in_ready=0. out_ready=1 -> next cycle np=0, vip=0, vvip=0, round_cnt=1, in_ready=1.
- Ballot (0,5,1) then (0,5,0) -> np=0. Ballots (1,9,1) and (3,0,1) -> err pulses once per ballot, each for one cycle, and bitmaps are unchanged.
- Ballot (0,31,1) in the same cycle as close -> PRESENT with np=32'h8000_0000.
- Assert reset during PRESENT (np=32'hFF) -> immediately np=0, out_valid=0, round_cnt=0; COLLECT after release.
- 256 empty rounds (close followed by out_ready=1) -> round_cnt wraps 255 -> 0.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the ballot collector: class codes, default sizes
// and the collector state encoding.
`timescale 1ns/1ps
package vote_pkg;

    // Ballot class codes carried on in_class
    localparam logic [1:0] CLS_NP   = 2'd0;
    localparam logic [1:0] CLS_VIP  = 2'd1;
    localparam logic [1:0] CLS_VVIP = 2'd2;
    localparam logic [1:0] CLS_BAD  = 2'd3;

    // Default voter population sizes
    localparam int NP_N_DEF  = 32;
    localparam int VIP_N_DEF = 8;

    // Collector state: gathering ballots, or presenting a frozen round
    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/vote_decode.sv
// Combinational ballot address decoder: turns a class/index pair into a
// one-hot set mask for exactly one bitmap, or flags the ballot illegal.
`timescale 1ns/1ps
module vote_decode
    import vote_pkg::*;
#(
    parameter int NP_N  = NP_N_DEF,
    parameter int VIP_N = VIP_N_DEF
)
(
    input  logic [1:0]       in_class,
    input  logic [4:0]       in_id,
    output logic [NP_N-1:0]  np_hit,
    output logic [VIP_N-1:0] vip_hit,
    output logic             vvip_hit,
    output logic             illegal
);

    localparam logic [NP_N-1:0]  NP_ONE  = {{(NP_N-1){1'b0}}, 1'b1};
    localparam logic [VIP_N-1:0] VIP_ONE = {{(VIP_N-1){1'b0}}, 1'b1};

    // Map the ballot address onto one bitmap bit; anything out of range is illegal
    always_comb begin
        np_hit   = '0;
        vip_hit  = '0;
        vvip_hit = 1'b0;
        illegal  = 1'b0;
        case (in_class)
            CLS_NP: begin
                if (int'(in_id) < NP_N) begin
                    np_hit = NP_ONE << in_id;
                end else begin
                    illegal = 1'b1;
                end
            end
            CLS_VIP: begin
                if (int'(in_id) < VIP_N) begin
                    vip_hit = VIP_ONE << in_id;
                end else begin
                    illegal = 1'b1;
                end
            end
            CLS_VVIP: begin
                if (in_id == 5'd0) begin
                    vvip_hit = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vote_ballot_collector.sv
// Ballot collector: accumulates serial ballots into np/vip/vvip bitmaps,
// freezes them on close and hands them to the voter under out_valid/out_ready.
`timescale 1ns/1ps
module vote_ballot_collector
    import vote_pkg::*;
#(
    parameter int NP_N  = NP_N_DEF,
    parameter int VIP_N = VIP_N_DEF,
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    input  logic [4:0]       in_id,
    input  logic             in_vote,
    input  logic             close,
    output logic [NP_N-1:0]  np,
    output logic [VIP_N-1:0] vip,
    output logic             vvip,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] round_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_r;
    state_e             state_nxt_s;
    logic [NP_N-1:0]    np_r;
    logic [NP_N-1:0]    np_nxt_s;
    logic [VIP_N-1:0]   vip_r;
    logic [VIP_N-1:0]   vip_nxt_s;
    logic               vvip_r;
    logic               vvip_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic [CNT_W-1:0]   round_cnt_r;
    logic [CNT_W-1:0]   round_cnt_nxt_s;

    logic [NP_N-1:0]    np_hit_s;
    logic [VIP_N-1:0]   vip_hit_s;
    logic               vvip_hit_s;
    logic               illegal_s;
    logic               in_ready_s;
    logic               accept_s;

    vote_decode #(
        .NP_N  (NP_N),
        .VIP_N (VIP_N)
    ) u_decode (
        .in_class (in_class),
        .in_id    (in_id),
        .np_hit   (np_hit_s),
        .vip_hit  (vip_hit_s),
        .vvip_hit (vvip_hit_s),
        .illegal  (illegal_s)
    );

    assign in_ready_s = (state_r == COLLECT);
    assign accept_s   = in_valid & in_ready_s;

    // Next-state and next-bitmap logic for the collect/present handshake
    always_comb begin
        state_nxt_s     = state_r;
        np_nxt_s        = np_r;
        vip_nxt_s       = vip_r;
        vvip_nxt_s      = vvip_r;
        err_nxt_s       = 1'b0;
        round_cnt_nxt_s = round_cnt_r;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        err_nxt_s = 1'b1;
                    end else if (in_vote) begin
                        np_nxt_s   = np_r | np_hit_s;
                        vip_nxt_s  = vip_r | vip_hit_s;
                        vvip_nxt_s = vvip_r | vvip_hit_s;
                    end else begin
                        np_nxt_s   = np_r & ~np_hit_s;
                        vip_nxt_s  = vip_r & ~vip_hit_s;
                        vvip_nxt_s = vvip_r & ~vvip_hit_s;
                    end
                end else begin
                    err_nxt_s = 1'b0;
                end
                // A ballot accepted alongside close still lands in this round
                if (close) begin
                    state_nxt_s = PRESENT;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    np_nxt_s        = '0;
                    vip_nxt_s       = '0;
                    vvip_nxt_s      = 1'b0;
                    round_cnt_nxt_s = round_cnt_r + CNT_ONE;
                    state_nxt_s     = COLLECT;
                end else begin
                    state_nxt_s = PRESENT;
                end
            end
            default: begin
                state_nxt_s = COLLECT;
            end
        endcase
    end

    // State, bitmap, error and round counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= COLLECT;
            np_r        <= '0;
            vip_r       <= '0;
            vvip_r      <= 1'b0;
            err_r       <= 1'b0;
            round_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            np_r        <= np_nxt_s;
            vip_r       <= vip_nxt_s;
            vvip_r      <= vvip_nxt_s;
            err_r       <= err_nxt_s;
            round_cnt_r <= round_cnt_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == PRESENT);
    assign np        = np_r;
    assign vip       = vip_r;
    assign vvip      = vvip_r;
    assign err       = err_r;
    assign round_cnt = round_cnt_r;

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for the ballot collector with hand-computed expectations.
`timescale 1ns/1ps
module tb_vote_ballot_collector;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_class;
    logic [4:0]  in_id;
    logic        in_vote;
    logic        close;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [7:0]  round_cnt;

    int tests;
    int fails;

    vote_ballot_collector #(
        .NP_N  (32),
        .VIP_N (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_id     (in_id),
        .in_vote   (in_vote),
        .close     (close),
        .np        (np),
        .vip       (vip),
        .vvip      (vvip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .round_cnt (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ballot for a single cycle
    task automatic ballot(input logic [1:0] c, input logic [4:0] id, input logic v);
        in_valid = 1'b1;
        in_class = c;
        in_id    = id;
        in_vote  = v;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_class  = 2'd0;
        in_id     = 5'd0;
        in_vote   = 1'b0;
        close     = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        check("rst_np", np, 32'h0);
        check("rst_ov", {31'd0, out_valid}, 32'h0);
        check("rst_cnt", {24'd0, round_cnt}, 32'h0);
        reset = 1'b1;
        tick();
        check("rel_ready", {31'd0, in_ready}, 32'h1);
        check("rel_vip", {24'd0, vip}, 32'h0);
        check("rel_vvip", {31'd0, vvip}, 32'h0);

        // Round 1: mixed classes
        ballot(2'd0, 5'd2, 1'b1);
        check("np_after_first", np, 32'h4);
        ballot(2'd0, 5'd7, 1'b1);
        ballot(2'd1, 5'd3, 1'b1);
        ballot(2'd2, 5'd0, 1'b1);
        close = 1'b1;
        tick();
        close = 1'b0;
        check("r1_np", np, 32'h84);
        check("r1_vip", {24'd0, vip}, 32'h08);
        check("r1_vvip", {31'd0, vvip}, 32'h1);
        check("r1_ov", {31'd0, out_valid}, 32'h1);
        check("r1_ready", {31'd0, in_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_class = 2'd0;
            in_id    = 5'd1;
            in_vote  = 1'b1;
            tick();
            check("hold_np", np, 32'h84);
            check("hold_ov", {31'd0, out_valid}, 32'h1);
            check("hold_ready", {31'd0, in_ready}, 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_np", np, 32'h0);
        check("hs_vip", {24'd0, vip}, 32'h0);
        check("hs_vvip", {31'd0, vvip}, 32'h0);
        check("hs_cnt", {24'd0, round_cnt}, 32'h1);
        check("hs_ready", {31'd0, in_ready}, 32'h1);
        check("hs_ov", {31'd0, out_valid}, 32'h0);

        // Cast then retract; duplicate cast idempotent
        ballot(2'd0, 5'd5, 1'b1);
        check("cast5", np, 32'h20);
        ballot(2'd0, 5'd5, 1'b1);
        check("dup5", np, 32'h20);
        check("dup_err", {31'd0, err}, 32'h0);
        ballot(2'd0, 5'd5, 1'b0);
        check("retract5", np, 32'h0);
        ballot(2'd0, 5'd6, 1'b0);
        check("retract_unset", np, 32'h0);
        check("retract_err", {31'd0, err}, 32'h0);

        // Illegal ballots
        ballot(2'd1, 5'd9, 1'b1);
        check("bad_vip_err", {31'd0, err}, 32'h1);
        check("bad_vip_map", {24'd0, vip}, 32'h0);
        tick();
        check("bad_vip_err_end", {31'd0, err}, 32'h0);
        ballot(2'd3, 5'd0, 1'b1);
        check("bad_cls_err", {31'd0, err}, 32'h1);
        check("bad_cls_np", np, 32'h0);
        ballot(2'd2, 5'd1, 1'b1);
        check("bad_vvip_err", {31'd0, err}, 32'h1);
        check("bad_vvip_map", {31'd0, vvip}, 32'h0);
        tick();
        check("bad_err_end", {31'd0, err}, 32'h0);

        // Ballot in the same cycle as close joins the round
        close = 1'b1;
        ballot(2'd0, 5'd31, 1'b1);
        close = 1'b0;
        check("close_np", np, 32'h8000_0000);
        check("close_ov", {31'd0, out_valid}, 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("r2_cnt", {24'd0, round_cnt}, 32'h2);

        // Reset during PRESENT
        for (int i = 0; i < 8; i++) begin
            ballot(2'd0, 5'(i), 1'b1);
        end
        close = 1'b1;
        tick();
        close = 1'b0;
        check("pre_rst_np", np, 32'hFF);
        check("pre_rst_ov", {31'd0, out_valid}, 32'h1);
        reset = 1'b0;
        #1;
        check("arst_np", np, 32'h0);
        check("arst_ov", {31'd0, out_valid}, 32'h0);
        check("arst_cnt", {24'd0, round_cnt}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, in_ready}, 32'h1);
        check("post_rst_ov", {31'd0, out_valid}, 32'h0);

        // Empty rounds with out_ready held high: two-cycle turnaround and wrap
        out_ready = 1'b1;
        for (int r = 1; r <= 256; r++) begin
            close = 1'b1;
            tick();
            close = 1'b0;
            if (r == 1) begin
                check("fast_ov", {31'd0, out_valid}, 32'h1);
            end
            tick();
            if (r == 1) begin
                check("fast_cnt", {24'd0, round_cnt}, 32'h1);
                check("fast_ready", {31'd0, in_ready}, 32'h1);
            end
            if (r == 255) begin
                check("cnt_255", {24'd0, round_cnt}, 32'hFF);
            end
            if (r == 256) begin
                check("cnt_wrap", {24'd0, round_cnt}, 32'h0);
            end
        end
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
